// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - serial pattern detector with IDLE/RUN/DONE control and match counter
// Optional feature: define OVERLAP_EN to keep history after a hit (overlapping detection).
module seq_det_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_pat,
    input  logic [2:0]       cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic             in,
    output logic             match,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

`ifdef OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [7:0]       hist_q, hist_d;
    logic [3:0]       fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       pat_q, pat_d;
    logic [2:0]       len_q, len_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             match_q, match_d;

    logic [7:0]       hist_sh;
    logic [3:0]       fill_inc;
    logic [7:0]       mask;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit;

    // Window compare includes the bit being accepted this cycle.
    always_comb begin
        hist_sh  = {hist_q[6:0], in};
        fill_inc = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
        mask     = 8'hFF >> (3'd7 - len_q);
        cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        hit      = (fill_inc >= ({1'b0, len_q} + 4'd1)) &&
                   (((hist_sh ^ pat_q) & mask) == 8'd0);
    end

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        len_d    = len_q;
        target_d = target_q;
        match_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    pat_d    = cfg_pat;
                    len_d    = cfg_len;
                    target_d = cfg_target;
                end
                if (!stop && start) begin
                    state_d = S_RUN;
                    hist_d  = 8'd0;
                    fill_d  = 4'd0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    hist_d = hist_sh;
                    fill_d = fill_inc;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        if (!OVERLAP) begin
                            hist_d = 8'd0;
                            fill_d = 4'd0;
                        end
                        if ((target_q != '0) && (cnt_inc == target_q)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                    hist_d  = 8'd0;
                    fill_d  = 4'd0;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hist_q   <= 8'd0;
            fill_q   <= 4'd0;
            cnt_q    <= '0;
            pat_q    <= 8'd0;
            len_q    <= 3'd0;
            target_q <= '0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            target_q <= target_d;
            match_q  <= match_d;
        end
    end

    assign match     = match_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign match_cnt = cnt_q;

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of match counter and target.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cfg_we  input  1  config write strobe, honoured only in IDLE.
REQ-005 SHALL have port cfg_pat  input  8  pattern; bit 0 = most recent serial bit.
REQ-006 SHALL have port cfg_len  input  3  pattern length minus one (1..8 bits).
REQ-007 SHALL have port cfg_target  input  CNT_W  matches before DONE; 0 = unlimited.
REQ-008 SHALL have port start  input  1  arm detector.
REQ-009 SHALL have port stop  input  1  abort or acknowledge, return to IDLE.
REQ-010 SHALL have port in_valid  input  1  serial bit qualifier.
REQ-011 SHALL have port in  input  1  serial data bit.
REQ-012 SHALL have port match  output  1  one-cycle registered match pulse.
REQ-013 SHALL have port busy  output  1  high in RUN.
REQ-014 SHALL have port done  output  1  high in DONE.
REQ-015 SHALL have port match_cnt  output  CNT_W  matches since last start.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE), both Moore.
REQ-017 SHALL latch cfg_pat, cfg_len, cfg_target on cfg_we in IDLE only; cfg_we in RUN/DONE ignored.
REQ-018 SHALL on start in IDLE or DONE go to RUN, clearing 8-bit history hist, fill counter, match_cnt; start in RUN ignored.
REQ-019 SHALL in RUN, per in_valid cycle, shift in into hist bit 0 and increment fill, saturating at 8.
REQ-020 SHALL detect a hit when the accepted bit makes fill >= len+1 and hist[len:0] == pat[len:0] (history including the new bit); in_valid low = no shift, no hit.
REQ-021 SHALL assert match exactly one cycle after the clock edge sampling the completing bit, for one cycle.
REQ-022 SHALL increment match_cnt on each hit, saturating at 2^CNT_W-1.
REQ-023 SHALL go RUN->DONE on the hit making match_cnt equal a non-zero target; no further bits accepted in DONE.
REQ-024 SHALL on stop in RUN or DONE go to IDLE; stop beats start and in_valid in same cycle; match_cnt held in IDLE.
REQ-025 SHALL ignore start and stop together in IDLE except stop priority (stays IDLE).

Reset
REQ-026 SHALL on rst go to IDLE with match=0, busy=0, done=0, match_cnt=0, hist=0, fill=0, pat=0, len=0, target=0; rst beats all inputs, mid-run included.

Configuration
REQ-027 SHALL, with OVERLAP_EN defined, keep hist and fill after a hit (overlapping detection).
REQ-028 SHALL, without OVERLAP_EN, clear hist and fill to 0 on a hit (non-overlapping detection).

Verification
REQ-029 SHALL cover: pat=8'b00011011, len=4, target=0, stream 1,1,0,1,1,0,1,1 -> OVERLAP_EN: 2 match pulses, match_cnt=2; else 1 pulse, match_cnt=1.
REQ-030 SHALL cover: target=3, len=0, pat bit0=1, stream 1,1,1,1 -> DONE after 3rd bit, match_cnt=3, 4th bit ignored.
REQ-031 SHALL cover: cfg_we with pat=8'hFF in RUN -> pattern unchanged, detection continues on old pattern.
REQ-032 SHALL cover: stop and in_valid=1 same cycle in RUN -> IDLE, bit not counted, match_cnt held.
REQ-033 SHALL cover: rst asserted mid-run with match_cnt=5 -> next cycle IDLE, all outputs 0.
REQ-034 SHALL cover: CNT_W=2, 5 hits, target=0 -> match_cnt saturates at 3, 5 match pulses.
